// File: rtl/trigger_rx.sv
// trigger_rx: receives an external trigger and the serial trigger ID that follows it.
// The ID arrives MSB first on a serial data/clock pair. It is offered to the readout
// side on a valid/ready slot, and a wrapping counter tracks how many IDs were delivered.
// A capture is abandoned on a clock stall, restarted on a new trigger, and a finished ID
// is dropped with a pulse when the output slot is still occupied.
module trigger_rx #(
    parameter int ID_WIDTH       = 16,
    parameter int SYNC_STAGES    = 2,
    parameter bit CLK_FALLING    = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                sampling_clk,
    input  logic                rst,
    input  logic                trig_in_async,
    input  logic                trig_id_async,
    input  logic                clk_in_async,
    output logic [ID_WIDTH-1:0] trigger_id,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [15:0]         trigger_count,
    output logic                busy,
    output logic                timeout_err,
    output logic                retrig_err,
    output logic                overrun_err
);

    localparam int CW = $clog2(ID_WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_BIT  = CW'(ID_WIDTH - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_trig_sync, r_id_sync, r_clk_sync;
    logic                   r_trig_prev, r_clk_prev;
    logic                   w_trig_s, w_id_s, w_clk_s;
    logic                   w_trig_rise, w_bit_edge;

    state_t                 r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]    r_shift, w_shift_nxt, w_shifted;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [TW-1:0]          r_tmr, w_tmr_nxt;
    logic                   w_done, w_tmo, w_rtg, w_load, w_ovr;

    logic [ID_WIDTH-1:0]    r_trigger_id;
    logic                   r_id_valid;
    logic [15:0]            r_trigger_count;
    logic                   r_timeout_err, r_retrig_err, r_overrun_err;

    // Bring the three cable lines into the sampling domain, plus one history flop
    // for the lines whose edges matter (trigger and serial clock).
    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) begin
            r_trig_sync <= '0;
            r_id_sync   <= '0;
            r_clk_sync  <= '0;
            r_trig_prev <= 1'b0;
            r_clk_prev  <= 1'b0;
        end else begin
            r_trig_sync <= {r_trig_sync[SYNC_STAGES-2:0], trig_in_async};
            r_id_sync   <= {r_id_sync[SYNC_STAGES-2:0], trig_id_async};
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], clk_in_async};
            r_trig_prev <= w_trig_s;
            r_clk_prev  <= w_clk_s;
        end
    end

    assign w_trig_s    = r_trig_sync[SYNC_STAGES-1];
    assign w_id_s      = r_id_sync[SYNC_STAGES-1];
    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_trig_rise = w_trig_s & ~r_trig_prev;
    // The data line goes through the same synchroniser depth as the clock line,
    // so the synced data bit is aligned with the synced clock edge.
    assign w_bit_edge  = CLK_FALLING ? (~w_clk_s & r_clk_prev) : (w_clk_s & ~r_clk_prev);
    assign w_shifted   = {r_shift[ID_WIDTH-2:0], w_id_s};

    // State register
    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and capture datapath. A new trigger outranks a bit edge, and a bit edge outranks the stall timer.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = r_tmr;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_rtg       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig_rise) begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_tmr_nxt   = '0;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_trig_rise) begin
                    w_rtg       = 1'b1;
                    w_shift_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_tmr_nxt   = '0;
                end else if (w_bit_edge) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_tmr_nxt   = '0;
                    if (r_cnt == LAST_BIT) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_tmr == LAST_TICK) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The slot can take a new word if it is empty or is being emptied in this same cycle.
    assign w_load = w_done & (~r_id_valid | id_ready);
    assign w_ovr  = w_done & r_id_valid & ~id_ready;

    // Capture registers, output slot, delivery counter and the one-cycle error pulses
    always_ff @(posedge sampling_clk or posedge rst) begin
        if (rst) begin
            r_shift         <= '0;
            r_cnt           <= '0;
            r_tmr           <= '0;
            r_trigger_id    <= '0;
            r_id_valid      <= 1'b0;
            r_trigger_count <= '0;
            r_timeout_err   <= 1'b0;
            r_retrig_err    <= 1'b0;
            r_overrun_err   <= 1'b0;
        end else begin
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_tmr         <= w_tmr_nxt;
            r_timeout_err <= w_tmo;
            r_retrig_err  <= w_rtg;
            r_overrun_err <= w_ovr;
            if (w_load) begin
                r_trigger_id    <= w_shifted;
                r_id_valid      <= 1'b1;
                r_trigger_count <= r_trigger_count + 16'd1;
            end else if (r_id_valid && id_ready) begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign trigger_id    = r_trigger_id;
    assign id_valid      = r_id_valid;
    assign trigger_count = r_trigger_count;
    assign busy          = (r_state == ST_CAPTURE);
    assign timeout_err   = r_timeout_err;
    assign retrig_err    = r_retrig_err;
    assign overrun_err   = r_overrun_err;

endmodule

// File: tb/tb_trigger_rx.sv
// tb_trigger_rx: directed bench for trigger_rx.
// dut0 is 16-bit, samples on the falling edge, and has a 32-cycle stall limit.
// dut1 is 8-bit and samples on the rising edge.
module tb_trigger_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        trig0, id0, sclk0, rdy0;
    logic        trig1, id1, sclk1, rdy1;
    logic [15:0] tid0, cnt0, cnt1;
    logic [7:0]  tid1;
    logic        vld0, busy0, tmo_p0, rtg_p0, ovr_p0;
    logic        vld1, busy1, tmo_p1, rtg_p1, ovr_p1;

    trigger_rx #(.ID_WIDTH(16), .SYNC_STAGES(2), .CLK_FALLING(1'b1), .TIMEOUT_CYCLES(32)) dut0 (
        .sampling_clk(clk), .rst(rst), .trig_in_async(trig0), .trig_id_async(id0),
        .clk_in_async(sclk0), .trigger_id(tid0), .id_valid(vld0), .id_ready(rdy0),
        .trigger_count(cnt0), .busy(busy0), .timeout_err(tmo_p0), .retrig_err(rtg_p0),
        .overrun_err(ovr_p0));

    trigger_rx #(.ID_WIDTH(8), .SYNC_STAGES(2), .CLK_FALLING(1'b0), .TIMEOUT_CYCLES(32)) dut1 (
        .sampling_clk(clk), .rst(rst), .trig_in_async(trig1), .trig_id_async(id1),
        .clk_in_async(sclk1), .trigger_id(tid1), .id_valid(vld1), .id_ready(rdy1),
        .trigger_count(cnt1), .busy(busy1), .timeout_err(tmo_p1), .retrig_err(rtg_p1),
        .overrun_err(ovr_p1));

    // Event monitor, sampled on the falling clock edge, away from the DUT's active edge
    int          acc0, vcyc0, ovr0, tmo0, rtg0, acc1, errs1;
    logic [15:0] got0;
    logic [7:0]  got1;
    logic        mon_clr;
    always @(negedge clk) begin
        if (mon_clr) begin
            acc0 = 0; vcyc0 = 0; ovr0 = 0; tmo0 = 0; rtg0 = 0; acc1 = 0; errs1 = 0;
            got0 = '0; got1 = '0;
        end else begin
            if (vld0) vcyc0++;
            if (vld0 && rdy0) begin acc0++; got0 = tid0; end
            if (ovr_p0) ovr0++;
            if (tmo_p0) tmo0++;
            if (rtg_p0) rtg0++;
            if (vld1 && rdy1) begin acc1++; got1 = tid1; end
            if (ovr_p1 || tmo_p1 || rtg_p1) errs1++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1; tick(1); mon_clr = 1'b0;
    endtask

    task automatic trig_pulse(input bit sel);
        if (!sel) begin trig0 = 1'b1; tick(4); trig0 = 1'b0; tick(4); end
        else      begin trig1 = 1'b1; tick(4); trig1 = 1'b0; tick(4); end
    endtask

    // Send cnt bits of w starting at bit hi, going downward.
    // dut0 samples each bit at the high-to-low clock edge; dut1 samples at the low-to-high edge.
    task automatic send_bits(input bit sel, input logic [15:0] w, input int hi, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (!sel) begin
                id0 = w[hi-i]; sclk0 = 1'b1; tick(4); sclk0 = 1'b0; tick(4);
            end else begin
                id1 = w[hi-i]; sclk1 = 1'b0; tick(4); sclk1 = 1'b1; tick(4);
            end
        end
    endtask

    initial begin
        rst = 1'b1; mon_clr = 1'b1;
        trig0 = 0; id0 = 0; sclk0 = 0; rdy0 = 0;
        trig1 = 0; id1 = 0; sclk1 = 0; rdy1 = 0;
        tick(3);
        // Reset state
        check("rst_tid",   tid0, 16'h0);
        check("rst_vld",   vld0, 1'b0);
        check("rst_cnt",   cnt0, 16'h0);
        check("rst_busy",  busy0, 1'b0);
        check("rst_errs",  {tmo_p0, rtg_p0, ovr_p0}, 3'b000);
        check("rst_vld1",  vld1, 1'b0);
        rst = 1'b0; tick(2);
        mon_clr = 1'b0;

        // Normal 16-bit falling-edge frame with the consumer always ready
        rdy0 = 1'b1;
        trig_pulse(0);
        check("norm_busy", busy0, 1'b1);
        send_bits(0, 16'hA5C3, 15, 16);
        tick(4);
        check("norm_acc",  acc0, 1);
        check("norm_id",   got0, 16'hA5C3);
        check("norm_vcyc", vcyc0, 1);
        check("norm_cnt",  cnt0, 16'd1);
        check("norm_busy_after", busy0, 1'b0);
        check("norm_vld_after",  vld0, 1'b0);

        // 8-bit rising-edge frame; opposite edges must not shift
        rdy1 = 1'b1;
        trig_pulse(1);
        send_bits(1, 16'h003C, 7, 4);
        check("w8_half_acc",  acc1, 0);
        check("w8_half_busy", busy1, 1'b1);
        send_bits(1, 16'h003C, 3, 4);
        tick(4);
        check("w8_acc",  acc1, 1);
        check("w8_id",   got1, 8'h3C);
        check("w8_cnt",  cnt1, 16'd1);
        check("w8_errs", errs1, 0);

        // Backpressure: the first frame is held, the second one overruns
        clear_mon();
        rdy0 = 1'b0;
        trig_pulse(0);
        send_bits(0, 16'h1234, 15, 16);
        tick(4);
        check("bp_vld1", vld0, 1'b1);
        check("bp_id1",  tid0, 16'h1234);
        check("bp_cnt1", cnt0, 16'd2);
        trig_pulse(0);
        send_bits(0, 16'hBEEF, 15, 16);
        tick(4);
        check("bp_ovr",  ovr0, 1);
        check("bp_vld2", vld0, 1'b1);
        check("bp_id2",  tid0, 16'h1234);
        check("bp_cnt2", cnt0, 16'd2);
        rdy0 = 1'b1;
        tick(1);
        check("bp_drain_vld", vld0, 1'b0);
        check("bp_drain_acc", acc0, 1);
        check("bp_drain_cnt", cnt0, 16'd2);

        // Stall timeout after 5 bits
        clear_mon();
        trig_pulse(0);
        send_bits(0, 16'hFFFF, 15, 5);
        tick(25);
        check("to_early_tmo",  tmo0, 0);
        check("to_early_busy", busy0, 1'b1);
        tick(20);
        check("to_tmo",  tmo0, 1);
        check("to_busy", busy0, 1'b0);
        check("to_acc",  acc0, 0);
        check("to_cnt",  cnt0, 16'd2);

        // Retrigger 10 bits into a frame, then a full frame
        clear_mon();
        trig_pulse(0);
        send_bits(0, 16'hFFFF, 15, 10);
        trig_pulse(0);
        send_bits(0, 16'h0F0F, 15, 16);
        tick(4);
        check("rt_rtg", rtg0, 1);
        check("rt_acc", acc0, 1);
        check("rt_id",  got0, 16'h0F0F);
        check("rt_cnt", cnt0, 16'd3);
        check("rt_other_errs", tmo0 + ovr0, 0);

        // Asynchronous reset in the middle of a capture
        trig_pulse(0);
        send_bits(0, 16'hFFFF, 15, 7);
        check("ar_busy_pre", busy0, 1'b1);
        rst = 1'b1;
        #1;
        check("ar_busy", busy0, 1'b0);
        check("ar_cnt",  cnt0, 16'h0);
        check("ar_tid",  tid0, 16'h0);
        check("ar_vld",  vld0, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(2);
        clear_mon();
        trig_pulse(0);
        send_bits(0, 16'h8001, 15, 16);
        tick(4);
        check("ar_new_acc", acc0, 1);
        check("ar_new_id",  got0, 16'h8001);
        check("ar_new_cnt", cnt0, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_rx.md
Name: trigger_rx

Overview:
- Parametrised successor of the trigger receiver.
- Synchronises the trigger, trigger-ID and serial-clock lines into the `sampling_clk` domain.
- Captures an `ID_WIDTH`-bit serial trigger ID, MSB first, and presents it on a valid/ready output with a delivered-trigger counter.
- Adds selectable clock edge, stall timeout, retrigger handling and overrun detection; sits between the external trigger cable and the readout/interrupt logic.

Parameters:
- `ID_WIDTH`, 16: trigger ID bits per frame. Legal range is ≥2.
- `SYNC_STAGES`, 2: flops per input synchroniser. Legal range is ≥2.
- `CLK_FALLING`, 1: 1 samples ID bits on the falling edge of `clk_in`; 0 samples on the rising edge.
- `TIMEOUT_CYCLES`, 1024: `sampling_clk` cycles without a serial-clock edge before an in-progress capture is aborted. Legal range is ≥2.

Ports:
- `sampling_clk`, in, 1: the block's only clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `trig_in_async`, in, 1: trigger line, asynchronous.
- `trig_id_async`, in, 1: serial trigger-ID data, asynchronous.
- `clk_in_async`, in, 1: serial ID clock, asynchronous.
- `trigger_id`, out, `ID_WIDTH`: captured ID; stable while `id_valid` is high.
- `id_valid`, out, 1: captured ID available.
- `id_ready`, in, 1: consumer accepts `trigger_id`.
- `trigger_count`, out, 16: number of IDs delivered; wraps.
- `busy`, out, 1: capture in progress.
- `timeout_err`, out, 1: one-cycle pulse, capture aborted by stall.
- `retrig_err`, out, 1: one-cycle pulse, capture restarted by a new trigger.
- `overrun_err`, out, 1: one-cycle pulse, completed ID dropped because the output slot was full.

Behaviour:
- Reset:
  - All synchroniser flops and previous-value flops clear to 0.
  - State is IDLE.
  - `trigger_id` = 0, `id_valid` = 0, `trigger_count` = 0, `busy` = 0, and all error pulses are 0.
  - Assertion mid-capture discards the partial ID immediately.
- Synchronisers:
  - Each async input passes through `SYNC_STAGES` flops.
  - One further flop holds the previous synced value.
- Edge detects (combinational from the synced and previous values):
  - `trig_rise` = synced & ~prev.
  - `bit_edge` = falling (~synced & prev) if `CLK_FALLING` = 1, else rising.
- Data sampling: the data bit taken is the synced `trig_id` in the same cycle as `bit_edge`.
- FSM states are IDLE and CAPTURE.
- IDLE:
  - On `trig_rise`: clear the shift register, bit counter and timer; go to CAPTURE.
  - `bit_edge` in IDLE is ignored.
- CAPTURE:
  - `busy` = 1.
  - Priority order each cycle: `trig_rise` > `bit_edge` > timeout.
  - On `trig_rise`: pulse `retrig_err`, clear shift register, bit counter and timer, and stay in CAPTURE. This applies even if the same cycle holds the final bit edge; that partial ID is discarded.
  - On `bit_edge`:
    - shift = {shift[`ID_WIDTH`-2:0], bit}; bit counter +1; timer cleared.
    - On the `ID_WIDTH`-th edge (counter == `ID_WIDTH`-1), the completed word is the combinational shifted value; go to IDLE.
    - If `id_valid` = 0, or `id_valid` & `id_ready` in this cycle: load `trigger_id`, set `id_valid` = 1, and increment `trigger_count` (mod 2^16).
    - Otherwise pulse `overrun_err`; the held `trigger_id` and `id_valid` are unchanged, and the count is unchanged.
  - With no edge: timer +1. When the timer == `TIMEOUT_CYCLES`-1, pulse `timeout_err`, discard the partial ID and go to IDLE.
- Output handshake:
  - `id_valid` falls on the cycle after `id_valid` & `id_ready`, unless a new ID is loaded in that same cycle, in which case it stays high with the new value.
  - `id_ready` while `id_valid` = 0 has no effect.
- Latency:
  - Async transition to synced value: `SYNC_STAGES` cycles.
  - `trigger_id` and `id_valid` register at the end of the cycle in which the final `bit_edge` is detected.
- Error pulses are exactly one cycle and mutually exclusive within a cycle.
- Bit counter width is clog2(`ID_WIDTH`); timer width is clog2(`TIMEOUT_CYCLES`).

Test Plan:
- Normal frame: trigger pulse, then 16 falling `clk_in` edges carrying 0xA5C3 MSB first, `id_ready` held high → `id_valid` for 1 cycle with `trigger_id` = 0xA5C3; `trigger_count` 0→1; `busy` low afterwards.
- Edge and width variant: `ID_WIDTH` = 8, `CLK_FALLING` = 0, rising-edge frame 0x3C → `trigger_id` = 0x3C; falling edges do not shift.
- Backpressure and overrun: `id_ready` = 0, two frames 0x1234 then 0xBEEF → first held with `id_valid` = 1; second gives one `overrun_err` pulse; `trigger_id` stays 0x1234; `trigger_count` = 1. Raising `id_ready` clears `id_valid` the next cycle.
- Stall timeout: `TIMEOUT_CYCLES` = 32, trigger then 5 bits then clock stopped → `timeout_err` pulses once after 32 idle cycles, state IDLE, no `id_valid`, count unchanged.
- Retrigger: 10 bits into a frame, new trigger pulse, then full frame 0x0F0F → one `retrig_err` pulse; output 0x0F0F only.
- Async reset mid-capture: `rst` asserted after 7 bits → all outputs 0 immediately; after release, a fresh frame 0x8001 captures correctly with `trigger_count` = 1.
